// File: rtl/ssm_sched_pkg.sv
// Shared definitions for the SSM head scheduler: FSM state encoding and
// the default watchdog limit.
package ssm_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

    localparam int unsigned TO_CYC_DEFAULT = 1024;

endpackage

// File: rtl/ssm_sched_wdog.sv
// Watchdog counter for the scheduler's WAIT state. Clears on clr, counts while
// en is high, and flags expiry on the cycle the count reaches TO_CYC-1.
module ssm_sched_wdog
    import ssm_sched_pkg::*;
#(
    parameter int unsigned TO_CYC = TO_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Expiry fires on the increment that would land on TO_CYC-1, so the
    // scheduler leaves WAIT on that same edge.
    assign expired = en && !clr && (cnt_q == CW'(TO_CYC - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ssm_head_scheduler.sv
// Sequences H heads through one shared SSM engine, one start/done handshake per head.
// Optional watchdog on the engine wait is enabled by defining SSM_SCHED_WDOG_EN.
module ssm_head_scheduler
    import ssm_sched_pkg::*;
#(
    parameter int unsigned H      = 4,
    parameter int unsigned HW     = 2,
    parameter int unsigned TO_CYC = TO_CYC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          eng_done,
    output logic          eng_start,
    output logic [HW-1:0] head_idx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [HW-1:0] LAST_HEAD = HW'(H - 1);

    if (((1 << HW) < H) || (H < 1) || (TO_CYC < 2)) begin : g_bad_params
        $error("ssm_head_scheduler: illegal H/HW/TO_CYC combination");
    end

    sched_state_e  state_q;
    logic [HW-1:0] head_q;
    logic          done_q;
    logic          wdog_exp;

`ifdef SSM_SCHED_WDOG_EN
    logic err_q;

    ssm_sched_wdog #(
        .TO_CYC (TO_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == ISSUE),
        .en      ((state_q == WAIT) && !eng_done),
        .expired (wdog_exp)
    );

    // Sticky until reset or the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            err_q <= 1'b0;
        end else if (wdog_exp && !abort) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign wdog_exp = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Abort outranks everything, including a same-cycle eng_done;
            // head_q is deliberately left untouched.
            if (abort && (state_q != IDLE)) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            head_q  <= '0;
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: state_q <= WAIT;
                    WAIT: begin
                        if (eng_done) begin
                            state_q <= (head_q == LAST_HEAD) ? DONE : NEXT;
                        end else if (wdog_exp) begin
                            state_q <= IDLE;
                        end
                    end
                    NEXT: begin
                        head_q  <= head_q + HW'(1);
                        state_q <= ISSUE;
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign eng_start = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign head_idx  = head_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ssm_head_scheduler.sv
// Directed bench for ssm_head_scheduler: an H=4 instance driven by an L=3
// engine model and an H=1 instance driven by hand; cycle 0 is the start cycle.
module tb_ssm_head_scheduler;

    localparam int L = 3;

    logic       clk = 1'b0;
    logic       rst, start, abort, eng_done;
    logic       eng_start, busy, done, err;
    logic [1:0] head_idx;
    logic       start1, abort1, eng_done1;
    logic       eng_start1, busy1, done1, err1;
    logic [0:0] head_idx1;

    always #5 clk = ~clk;

    ssm_head_scheduler #(.H(4), .HW(2), .TO_CYC(16)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .eng_done(eng_done),
        .eng_start(eng_start), .head_idx(head_idx), .busy(busy), .done(done), .err(err)
    );

    ssm_head_scheduler #(.H(1), .HW(1), .TO_CYC(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .eng_done(eng_done1),
        .eng_start(eng_start1), .head_idx(head_idx1), .busy(busy1), .done(done1), .err(err1)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;
    int   last_es;
    int   es_cnt, done_cnt, es1_cnt, done1_cnt;
    logic model_en, force_done;
    logic es_log[64], done_log[64], busy_log[64], err_log[64];
    logic [1:0] hi_log[64];
    logic es1_log[64], done1_log[64], busy1_log[64];
    logic [0:0] hi1_log[64];

    // One clock cycle: apply engine response, sample at negedge, advance.
    task automatic tick();
        eng_done = force_done || (model_en && (last_es >= 0) && (cyc == last_es + L));
        @(negedge clk);
        if (cyc < 64) begin
            es_log[cyc]    = eng_start;
            done_log[cyc]  = done;
            busy_log[cyc]  = busy;
            err_log[cyc]   = err;
            hi_log[cyc]    = head_idx;
            es1_log[cyc]   = eng_start1;
            done1_log[cyc] = done1;
            busy1_log[cyc] = busy1;
            hi1_log[cyc]   = head_idx1;
        end
        if (eng_start === 1'b1) begin last_es = cyc; es_cnt++; end
        if (done === 1'b1) done_cnt++;
        if (eng_start1 === 1'b1) es1_cnt++;
        if (done1 === 1'b1) done1_cnt++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_run();
        cyc = 0; last_es = -1;
        es_cnt = 0; done_cnt = 0; es1_cnt = 0; done1_cnt = 0;
        start = 0; abort = 0; force_done = 0; model_en = 1;
        start1 = 0; abort1 = 0; eng_done1 = 0;
        for (int i = 0; i < 64; i++) begin
            es_log[i] = 0; done_log[i] = 0; busy_log[i] = 0; err_log[i] = 0; hi_log[i] = 0;
            es1_log[i] = 0; done1_log[i] = 0; busy1_log[i] = 0; hi1_log[i] = 0;
        end
    endtask

    task automatic test_reset();
        begin_run();
        model_en = 0;
        rst = 1;
        tick();
        tick();
        n_checks++; if (eng_start !== 1'b0) $display("FAIL reset_eng_start: got %b expected 0", eng_start); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        n_checks++; if (head_idx !== 2'd0) $display("FAIL reset_head_idx: got %0d expected 0", head_idx); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy_h1: got %b expected 0", busy1); else n_pass++;
        rst = 0;
        tick();
    endtask

    task automatic test_full_run();
        begin_run();
        for (int c = 0; c < 25; c++) begin
            start = (c == 0);
            tick();
        end
        start = 0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (es_log[1 + k * 5] !== 1'b1) $display("FAIL run_eng_start_head%0d: got %b expected 1 at cycle %0d", k, es_log[1 + k * 5], 1 + k * 5); else n_pass++;
            n_checks++; if (hi_log[1 + k * 5] !== 2'(k)) $display("FAIL run_head_idx%0d: got %0d expected %0d", k, hi_log[1 + k * 5], k); else n_pass++;
        end
        n_checks++; if (es_cnt != 4) $display("FAIL run_eng_start_count: got %0d expected 4", es_cnt); else n_pass++;
        n_checks++; if (done_log[21] !== 1'b1) $display("FAIL run_done_c21: got %b expected 1", done_log[21]); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL run_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (busy_log[0] !== 1'b0) $display("FAIL run_busy_c0: got %b expected 0", busy_log[0]); else n_pass++;
        n_checks++; if (busy_log[20] !== 1'b1) $display("FAIL run_busy_c20: got %b expected 1", busy_log[20]); else n_pass++;
        n_checks++; if (busy_log[21] !== 1'b0) $display("FAIL run_busy_c21: got %b expected 0", busy_log[21]); else n_pass++;
        n_checks++; if (hi_log[24] !== 2'd3) $display("FAIL run_head_hold: got %0d expected 3", hi_log[24]); else n_pass++;
    endtask

    task automatic test_start_ignored();
        begin_run();
        for (int c = 0; c < 25; c++) begin
            start = (c == 0) || (c == 5);
            tick();
        end
        start = 0;
        n_checks++; if (es_cnt != 4) $display("FAIL restart_eng_start_count: got %0d expected 4", es_cnt); else n_pass++;
        n_checks++; if (es_log[16] !== 1'b1) $display("FAIL restart_eng_start_c16: got %b expected 1", es_log[16]); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL restart_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (done_log[21] !== 1'b1) $display("FAIL restart_done_c21: got %b expected 1", done_log[21]); else n_pass++;
    endtask

    task automatic test_abort();
        begin_run();
        for (int c = 0; c < 20; c++) begin
            start = (c == 0);
            abort = (c == 8);
            force_done = (c == 8);
            tick();
        end
        start = 0; abort = 0; force_done = 0;
        n_checks++; if (busy_log[9] !== 1'b0) $display("FAIL abort_busy_c9: got %b expected 0", busy_log[9]); else n_pass++;
        n_checks++; if (hi_log[9] !== 2'd1) $display("FAIL abort_head_held: got %0d expected 1", hi_log[9]); else n_pass++;
        n_checks++; if (es_cnt != 2) $display("FAIL abort_eng_start_count: got %0d expected 2", es_cnt); else n_pass++;
        n_checks++; if (done_cnt != 0) $display("FAIL abort_done_count: got %0d expected 0", done_cnt); else n_pass++;
        n_checks++; if (busy_log[19] !== 1'b0) $display("FAIL abort_busy_c19: got %b expected 0", busy_log[19]); else n_pass++;
    endtask

    task automatic test_abort_start_idle();
        begin_run();
        for (int c = 0; c < 25; c++) begin
            start = (c == 0);
            abort = (c == 0);
            tick();
        end
        start = 0; abort = 0;
        n_checks++; if (es_log[1] !== 1'b1) $display("FAIL idle_abort_eng_start: got %b expected 1", es_log[1]); else n_pass++;
        n_checks++; if (busy_log[1] !== 1'b1) $display("FAIL idle_abort_busy: got %b expected 1", busy_log[1]); else n_pass++;
        n_checks++; if (done_log[21] !== 1'b1) $display("FAIL idle_abort_done_c21: got %b expected 1", done_log[21]); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        begin_run();
        for (int c = 0; c < 16; c++) begin
            start = (c == 0);
            rst = (c == 7);
            tick();
        end
        start = 0; rst = 0;
        n_checks++; if (hi_log[7] !== 2'd1) $display("FAIL rstmid_head_c7: got %0d expected 1", hi_log[7]); else n_pass++;
        n_checks++; if (busy_log[8] !== 1'b0) $display("FAIL rstmid_busy_c8: got %b expected 0", busy_log[8]); else n_pass++;
        n_checks++; if (hi_log[8] !== 2'd0) $display("FAIL rstmid_head_c8: got %0d expected 0", hi_log[8]); else n_pass++;
        n_checks++; if (es_log[8] !== 1'b0) $display("FAIL rstmid_eng_start_c8: got %b expected 0", es_log[8]); else n_pass++;
        n_checks++; if (busy_log[10] !== 1'b0) $display("FAIL rstmid_busy_c10: got %b expected 0", busy_log[10]); else n_pass++;
        n_checks++; if (es_cnt != 2) $display("FAIL rstmid_eng_start_count: got %0d expected 2", es_cnt); else n_pass++;
        n_checks++; if (done_cnt != 0) $display("FAIL rstmid_done_count: got %0d expected 0", done_cnt); else n_pass++;
    endtask

    task automatic test_watchdog();
        begin_run();
        model_en = 0;
        for (int c = 0; c < 30; c++) begin
            start = (c == 0);
            tick();
        end
        start = 0;
        n_checks++; if (done_cnt != 0) $display("FAIL wdog_done_count: got %0d expected 0", done_cnt); else n_pass++;
`ifdef SSM_SCHED_WDOG_EN
        n_checks++; if (busy_log[16] !== 1'b1) $display("FAIL wdog_busy_c16: got %b expected 1", busy_log[16]); else n_pass++;
        n_checks++; if (busy_log[17] !== 1'b0) $display("FAIL wdog_busy_c17: got %b expected 0", busy_log[17]); else n_pass++;
        n_checks++; if (err_log[17] !== 1'b1) $display("FAIL wdog_err_c17: got %b expected 1", err_log[17]); else n_pass++;
        begin_run();
        model_en = 0;
        start = 1;
        tick();
        start = 0;
        tick();
        n_checks++; if (err_log[0] !== 1'b1) $display("FAIL wdog_err_sticky: got %b expected 1", err_log[0]); else n_pass++;
        n_checks++; if (err_log[1] !== 1'b0) $display("FAIL wdog_err_cleared: got %b expected 0", err_log[1]); else n_pass++;
`else
        n_checks++; if (busy_log[29] !== 1'b1) $display("FAIL wdog_off_busy: got %b expected 1", busy_log[29]); else n_pass++;
        n_checks++; if (err_log[29] !== 1'b0) $display("FAIL wdog_off_err: got %b expected 0", err_log[29]); else n_pass++;
`endif
        abort = 1;
        tick();
        abort = 0;
        n_checks++; if (busy !== 1'b0) $display("FAIL wdog_abort_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_single_head();
        begin_run();
        for (int c = 0; c < 8; c++) begin
            start1 = (c == 0);
            eng_done1 = (c == 2);
            tick();
        end
        start1 = 0; eng_done1 = 0;
        n_checks++; if (es1_log[1] !== 1'b1) $display("FAIL h1_eng_start_c1: got %b expected 1", es1_log[1]); else n_pass++;
        n_checks++; if (es1_cnt != 1) $display("FAIL h1_eng_start_count: got %0d expected 1", es1_cnt); else n_pass++;
        n_checks++; if (busy1_log[3] !== 1'b1) $display("FAIL h1_busy_c3: got %b expected 1", busy1_log[3]); else n_pass++;
        n_checks++; if (done1_log[4] !== 1'b1) $display("FAIL h1_done_c4: got %b expected 1", done1_log[4]); else n_pass++;
        n_checks++; if (done1_cnt != 1) $display("FAIL h1_done_count: got %0d expected 1", done1_cnt); else n_pass++;
        n_checks++; if (hi1_log[4] !== 1'b0) $display("FAIL h1_head_idx: got %0d expected 0", hi1_log[4]); else n_pass++;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; eng_done = 0;
        start1 = 0; abort1 = 0; eng_done1 = 0;
        model_en = 0; force_done = 0; cyc = 0; last_es = -1;
        test_reset();
        test_full_run();
        test_start_ignored();
        test_abort();
        test_abort_start_idle();
        test_reset_midrun();
        test_watchdog();
        test_single_head();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
